datapath_p: RTL and testbench

DATAPATH_P -- requirements
Module: datapath_p

---
 rtl/datapath_p_if.sv | 39 +++
 rtl/datapath_p.sv | 178 +++++++++++++++++
 tb/tb_datapath_p.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_p_if.sv
// Control, memory and architectural-register bundle for the datapath.
// The master side drives the control word; the slave side is the datapath.
interface datapath_p_if #(
    parameter int WIDTH = 16
);
    logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic             GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]       PCMUX;
    logic             DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0]       ADDR2MUX;
    logic [1:0]       ALUK;
    logic             MIO_EN;
    logic             Mem_Rdy;
    logic [WIDTH-1:0] MDR_In;

    logic [WIDTH-1:0] MAR, MDR, PC, IR;
    logic             BEN;
    logic [2:0]       NZP;
    logic [9:0]       LED;
    logic             Mdr_Busy;
    logic             Bus_Err;
    logic             Bus_Err_Sticky;

    modport master (
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output MIO_EN, Mem_Rdy, MDR_In,
        input  MAR, MDR, PC, IR, BEN, NZP, LED, Mdr_Busy, Bus_Err, Bus_Err_Sticky
    );

    modport slave (
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  MIO_EN, Mem_Rdy, MDR_In,
        output MAR, MDR, PC, IR, BEN, NZP, LED, Mdr_Busy, Bus_Err, Bus_Err_Sticky
    );
endinterface

// File: rtl/datapath_p.sv
// LC-3 style single-bus datapath: register file, ALU, address adder, PC/MAR/MDR/IR,
// condition codes, branch enable, LED latch and an MDR memory-wait FSM.
module datapath_p #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic          Clk,
    input logic          Reset,
    datapath_p_if.slave  bus_if
);

    typedef enum logic {IDLE, WAIT} mdr_state_t;

    logic [WIDTH-1:0] pc_r, mar_r, mdr_r, ir_r;
    logic [WIDTH-1:0] regs_r [8];
    logic [2:0]       nzp_r;
    logic             ben_r;
    logic [9:0]       led_r;
    logic             sticky_r;
    mdr_state_t       state_r;
    logic             busy_r;

    function automatic logic signed [WIDTH-1:0] sext5(input logic [4:0] f);
        return {{(WIDTH-5){f[4]}}, f};
    endfunction

    function automatic logic signed [WIDTH-1:0] sext6(input logic [5:0] f);
        return {{(WIDTH-6){f[5]}}, f};
    endfunction

    function automatic logic signed [WIDTH-1:0] sext9(input logic [8:0] f);
        return {{(WIDTH-9){f[8]}}, f};
    endfunction

    function automatic logic signed [WIDTH-1:0] sext11(input logic [10:0] f);
        return {{(WIDTH-11){f[10]}}, f};
    endfunction

    logic [3:0]              gates;
    logic                    bus_err;
    logic [2:0]              sr1_idx, sr2_idx, dr_idx;
    logic signed [WIDTH-1:0] sr1, sr2;
    logic signed [WIDTH-1:0] alu_b, alu_out;
    logic signed [WIDTH-1:0] addr_a, addr_b, adder_sum;
    logic [WIDTH-1:0]        bus;
    logic                    bus_n, bus_z;

    assign gates   = {bus_if.GatePC, bus_if.GateMDR, bus_if.GateALU, bus_if.GateMARMUX};
    // Clearing the lowest set bit leaves something only when two or more gates are on.
    assign bus_err = |(gates & (gates - 4'd1));

    assign sr1_idx = bus_if.SR1MUX ? ir_r[8:6] : ir_r[11:9];
    assign sr2_idx = ir_r[2:0];
    assign dr_idx  = bus_if.DRMUX ? 3'd7 : ir_r[11:9];
    assign sr1     = regs_r[sr1_idx];
    assign sr2     = regs_r[sr2_idx];
    assign alu_b   = bus_if.SR2MUX ? sext5(ir_r[4:0]) : sr2;

    always_comb begin
        alu_out = sr1;
        case (bus_if.ALUK)
            2'b00:   alu_out = sr1 + alu_b;
            2'b01:   alu_out = sr1 & alu_b;
            2'b10:   alu_out = ~sr1;
            default: alu_out = sr1;
        endcase
    end

    assign addr_a = bus_if.ADDR1MUX ? sr1 : pc_r;

    always_comb begin
        addr_b = '0;
        case (bus_if.ADDR2MUX)
            2'b00:   addr_b = '0;
            2'b01:   addr_b = sext6(ir_r[5:0]);
            2'b10:   addr_b = sext9(ir_r[8:0]);
            default: addr_b = sext11(ir_r[10:0]);
        endcase
    end

    assign adder_sum = addr_a + addr_b;

    // A contended or idle bus reads as zero rather than a wired-OR of sources.
    always_comb begin
        bus = '0;
        case (gates)
            4'b1000: bus = pc_r;
            4'b0100: bus = mdr_r;
            4'b0010: bus = alu_out;
            4'b0001: bus = adder_sum;
            default: bus = '0;
        endcase
    end

    assign bus_n = bus[WIDTH-1];
    assign bus_z = (bus == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r     <= RESET_PC;
            mar_r    <= '0;
            ir_r     <= '0;
            nzp_r    <= 3'b010;
            ben_r    <= 1'b0;
            led_r    <= '0;
            sticky_r <= 1'b0;
            for (int i = 0; i < 8; i++) regs_r[i] <= '0;
        end else begin
            if (bus_if.LD_PC) begin
                case (bus_if.PCMUX)
                    2'b00:   pc_r <= pc_r + 1'b1;
                    2'b01:   pc_r <= bus;
                    2'b10:   pc_r <= adder_sum;
                    default: pc_r <= pc_r;
                endcase
            end
            if (bus_if.LD_MAR) mar_r <= bus;
            if (bus_if.LD_IR)  ir_r  <= bus;
            if (bus_if.LD_REG) regs_r[dr_idx] <= bus;
            if (bus_if.LD_CC)  nzp_r <= {bus_n, bus_z, ~bus_n & ~bus_z};
            if (bus_if.LD_BEN)
                ben_r <= (ir_r[11] & nzp_r[2]) | (ir_r[10] & nzp_r[1]) | (ir_r[9] & nzp_r[0]);
            if (bus_if.LD_LED) led_r <= ir_r[9:0];
            if (bus_err) sticky_r <= 1'b1;
        end
    end

    // MDR load FSM; a bus load always wins, including over a late Mem_Rdy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            mdr_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus_if.LD_MDR) begin
                        if (!bus_if.MIO_EN) begin
                            mdr_r <= bus;
                        end else if (bus_if.Mem_Rdy) begin
                            mdr_r <= bus_if.MDR_In;
                        end else begin
                            state_r <= WAIT;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus_if.LD_MDR && !bus_if.MIO_EN) begin
                        mdr_r   <= bus;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus_if.Mem_Rdy) begin
                        mdr_r   <= bus_if.MDR_In;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.PC             = pc_r;
    assign bus_if.MAR            = mar_r;
    assign bus_if.MDR            = mdr_r;
    assign bus_if.IR             = ir_r;
    assign bus_if.NZP            = nzp_r;
    assign bus_if.BEN            = ben_r;
    assign bus_if.LED            = led_r;
    assign bus_if.Mdr_Busy       = busy_r;
    assign bus_if.Bus_Err        = bus_err;
    assign bus_if.Bus_Err_Sticky = sticky_r;

endmodule

// File: tb/tb_datapath_p.sv
// Directed bench for datapath_p: a 16-bit instance for most features and a
// 32-bit instance (RESET_PC = 0x1000) for wide sign-extension in the address adder.
module tb_datapath_p;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    datapath_p_if #(.WIDTH(16)) d16 ();
    datapath_p_if #(.WIDTH(32)) d32 ();

    datapath_p #(.WIDTH(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus_if(d16));
    datapath_p #(.WIDTH(32), .RESET_PC(32'h0000_1000)) dut32 (.Clk(Clk), .Reset(Reset), .bus_if(d32));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear16();
        d16.LD_MAR = 0; d16.LD_MDR = 0; d16.LD_IR = 0; d16.LD_BEN = 0;
        d16.LD_CC = 0; d16.LD_REG = 0; d16.LD_PC = 0; d16.LD_LED = 0;
        d16.GatePC = 0; d16.GateMDR = 0; d16.GateALU = 0; d16.GateMARMUX = 0;
        d16.PCMUX = 0; d16.DRMUX = 0; d16.SR1MUX = 0; d16.SR2MUX = 0;
        d16.ADDR1MUX = 0; d16.ADDR2MUX = 0; d16.ALUK = 0;
        d16.MIO_EN = 0; d16.Mem_Rdy = 0; d16.MDR_In = '0;
    endtask

    task automatic clear32();
        d32.LD_MAR = 0; d32.LD_MDR = 0; d32.LD_IR = 0; d32.LD_BEN = 0;
        d32.LD_CC = 0; d32.LD_REG = 0; d32.LD_PC = 0; d32.LD_LED = 0;
        d32.GatePC = 0; d32.GateMDR = 0; d32.GateALU = 0; d32.GateMARMUX = 0;
        d32.PCMUX = 0; d32.DRMUX = 0; d32.SR1MUX = 0; d32.SR2MUX = 0;
        d32.ADDR1MUX = 0; d32.ADDR2MUX = 0; d32.ALUK = 0;
        d32.MIO_EN = 0; d32.Mem_Rdy = 0; d32.MDR_In = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic mem16(input logic [15:0] v);
        clear16();
        d16.LD_MDR = 1; d16.MIO_EN = 1; d16.Mem_Rdy = 1; d16.MDR_In = v;
        tick();
        clear16();
    endtask

    task automatic set_ir16(input logic [15:0] v);
        mem16(v);
        d16.GateMDR = 1; d16.LD_IR = 1;
        tick();
        clear16();
    endtask

    // Copies SR1 onto MAR through the ALU pass-A operation.
    task automatic reg_to_mar16(input logic sr1mux);
        clear16();
        d16.GateALU = 1; d16.ALUK = 2'b11; d16.SR1MUX = sr1mux; d16.LD_MAR = 1;
        tick();
        clear16();
    endtask

    task automatic test_reset();
        set_ir16(16'h1261);
        mem16(16'hFFFF);
        d16.GateMDR = 1; d16.LD_REG = 1; d16.LD_CC = 1; d16.LD_LED = 1;
        d16.LD_MAR = 1; d16.LD_PC = 1; d16.PCMUX = 2'b01;
        tick();
        clear16();
        reg_to_mar16(1'b1);
        checks++; if (d16.MAR !== 16'hFFFF) begin errors++; $display("FAIL pre_reset_r1 got %h want ffff", d16.MAR); end
        do_reset();
        checks++; if (d16.PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", d16.PC); end
        checks++; if (d16.MAR !== 16'h0000) begin errors++; $display("FAIL reset_mar got %h want 0000", d16.MAR); end
        checks++; if (d16.MDR !== 16'h0000) begin errors++; $display("FAIL reset_mdr got %h want 0000", d16.MDR); end
        checks++; if (d16.IR !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want 0000", d16.IR); end
        checks++; if (d16.NZP !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b want 010", d16.NZP); end
        checks++; if (d16.LED !== 10'h000) begin errors++; $display("FAIL reset_led got %h want 000", d16.LED); end
        checks++; if (d16.BEN !== 1'b0 || d16.Mdr_Busy !== 1'b0 || d16.Bus_Err_Sticky !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ben=%b busy=%b sticky=%b want 0 0 0", d16.BEN, d16.Mdr_Busy, d16.Bus_Err_Sticky);
        end
        checks++; if (d32.PC !== 32'h0000_1000) begin errors++; $display("FAIL reset_pc32 got %h want 00001000", d32.PC); end
        set_ir16(16'h1261);
        reg_to_mar16(1'b1);
        checks++; if (d16.MAR !== 16'h0000) begin errors++; $display("FAIL reset_r1 got %h want 0000", d16.MAR); end
    endtask

    task automatic test_pc();
        do_reset();
        d16.LD_PC = 1; d16.PCMUX = 2'b00;
        repeat (3) tick();
        checks++; if (d16.PC !== 16'h0003) begin errors++; $display("FAIL pc_inc3 got %h want 0003", d16.PC); end
        d16.PCMUX = 2'b11;
        tick();
        checks++; if (d16.PC !== 16'h0003) begin errors++; $display("FAIL pc_hold got %h want 0003", d16.PC); end
        clear16();
        mem16(16'hFFFF);
        d16.GateMDR = 1; d16.LD_PC = 1; d16.PCMUX = 2'b01;
        tick();
        checks++; if (d16.PC !== 16'hFFFF) begin errors++; $display("FAIL pc_bus got %h want ffff", d16.PC); end
        clear16();
        d16.LD_PC = 1; d16.PCMUX = 2'b00;
        tick();
        checks++; if (d16.PC !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", d16.PC); end
        clear16();
        set_ir16(16'h0005);
        d16.LD_PC = 1; d16.PCMUX = 2'b10; d16.ADDR1MUX = 0; d16.ADDR2MUX = 2'b01;
        tick();
        checks++; if (d16.PC !== 16'h0005) begin errors++; $display("FAIL pc_adder_pos got %h want 0005", d16.PC); end
        clear16();
        set_ir16(16'h003F);
        d16.LD_PC = 1; d16.PCMUX = 2'b10; d16.ADDR1MUX = 0; d16.ADDR2MUX = 2'b01;
        tick();
        checks++; if (d16.PC !== 16'h0004) begin errors++; $display("FAIL pc_adder_neg got %h want 0004", d16.PC); end
        clear16();
    endtask

    task automatic test_alu_cc_ben();
        do_reset();
        set_ir16(16'h1261);
        mem16(16'hFFFF);
        d16.GateMDR = 1; d16.LD_REG = 1; d16.LD_CC = 1;
        tick();
        clear16();
        checks++; if (d16.NZP !== 3'b100) begin errors++; $display("FAIL cc_neg got %b want 100", d16.NZP); end
        d16.GateALU = 1; d16.SR1MUX = 1; d16.SR2MUX = 1; d16.ALUK = 2'b00; d16.LD_REG = 1; d16.LD_CC = 1;
        tick();
        clear16();
        checks++; if (d16.NZP !== 3'b010) begin errors++; $display("FAIL cc_zero got %b want 010", d16.NZP); end
        reg_to_mar16(1'b1);
        checks++; if (d16.MAR !== 16'h0000) begin errors++; $display("FAIL add_wrap_r1 got %h want 0000", d16.MAR); end
        set_ir16(16'h0400);
        d16.LD_BEN = 1;
        tick();
        clear16();
        checks++; if (d16.BEN !== 1'b1) begin errors++; $display("FAIL ben_z got %b want 1", d16.BEN); end
        set_ir16(16'h0800);
        d16.LD_BEN = 1;
        tick();
        clear16();
        checks++; if (d16.BEN !== 1'b0) begin errors++; $display("FAIL ben_n got %b want 0", d16.BEN); end
        set_ir16(16'h1261);
        d16.GateALU = 1; d16.ALUK = 2'b10; d16.SR1MUX = 1; d16.LD_MAR = 1; d16.LD_CC = 1;
        tick();
        clear16();
        checks++; if (d16.MAR !== 16'hFFFF || d16.NZP !== 3'b100) begin
            errors++; $display("FAIL alu_not got mar=%h nzp=%b want ffff 100", d16.MAR, d16.NZP);
        end
        mem16(16'h00FF);
        d16.GateMDR = 1; d16.LD_REG = 1; d16.DRMUX = 1;
        tick();
        clear16();
        set_ir16(16'h51F3);
        d16.GateALU = 1; d16.ALUK = 2'b01; d16.SR1MUX = 1; d16.SR2MUX = 1; d16.LD_MAR = 1;
        tick();
        clear16();
        checks++; if (d16.MAR !== 16'h00F3) begin errors++; $display("FAIL alu_and_imm got %h want 00f3", d16.MAR); end
    endtask

    task automatic test_led();
        set_ir16(16'h1261);
        d16.LD_LED = 1;
        tick();
        clear16();
        checks++; if (d16.LED !== 10'h261) begin errors++; $display("FAIL led_load got %h want 261", d16.LED); end
        set_ir16(16'h0000);
        tick();
        checks++; if (d16.LED !== 10'h261) begin errors++; $display("FAIL led_hold got %h want 261", d16.LED); end
    endtask

    task automatic test_bus_err();
        clear16();
        d16.GatePC = 1; d16.GateALU = 1; d16.LD_MAR = 1;
        #1;
        checks++; if (d16.Bus_Err !== 1'b1 || d16.Bus_Err_Sticky !== 1'b0) begin
            errors++; $display("FAIL bus_err_comb got err=%b sticky=%b want 1 0", d16.Bus_Err, d16.Bus_Err_Sticky);
        end
        tick();
        clear16();
        checks++; if (d16.MAR !== 16'h0000 || d16.Bus_Err_Sticky !== 1'b1) begin
            errors++; $display("FAIL bus_err_edge got mar=%h sticky=%b want 0000 1", d16.MAR, d16.Bus_Err_Sticky);
        end
        tick();
        tick();
        checks++; if (d16.Bus_Err !== 1'b0 || d16.Bus_Err_Sticky !== 1'b1) begin
            errors++; $display("FAIL bus_err_hold got err=%b sticky=%b want 0 1", d16.Bus_Err, d16.Bus_Err_Sticky);
        end
        do_reset();
        checks++; if (d16.Bus_Err_Sticky !== 1'b0) begin errors++; $display("FAIL bus_err_clr got %b want 0", d16.Bus_Err_Sticky); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem16(16'h1234);
        checks++; if (d16.MDR !== 16'h1234) begin errors++; $display("FAIL mdr_mem_rdy got %h want 1234", d16.MDR); end
        d16.LD_MDR = 1; d16.MIO_EN = 1; d16.Mem_Rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (d16.Mdr_Busy !== 1'b1 || d16.MDR !== 16'h1234) begin
                errors++; $display("FAIL mdr_wait%0d got busy=%b mdr=%h want 1 1234", i, d16.Mdr_Busy, d16.MDR);
            end
        end
        d16.Mem_Rdy = 1; d16.MDR_In = 16'hBEEF;
        tick();
        clear16();
        checks++; if (d16.MDR !== 16'hBEEF || d16.Mdr_Busy !== 1'b0) begin
            errors++; $display("FAIL mdr_done got mdr=%h busy=%b want beef 0", d16.MDR, d16.Mdr_Busy);
        end
        d16.LD_MDR = 1; d16.MIO_EN = 1; d16.Mem_Rdy = 0;
        tick();
        checks++; if (d16.Mdr_Busy !== 1'b1) begin errors++; $display("FAIL mdr_wait_rst_pre got %b want 1", d16.Mdr_Busy); end
        do_reset();
        clear16();
        checks++; if (d16.MDR !== 16'h0000 || d16.Mdr_Busy !== 1'b0) begin
            errors++; $display("FAIL mdr_wait_rst got mdr=%h busy=%b want 0000 0", d16.MDR, d16.Mdr_Busy);
        end
        d16.LD_PC = 1; d16.PCMUX = 2'b00;
        repeat (2) tick();
        clear16();
        d16.LD_MDR = 1; d16.MIO_EN = 1; d16.Mem_Rdy = 0;
        tick();
        d16.MIO_EN = 0; d16.GatePC = 1; d16.Mem_Rdy = 1; d16.MDR_In = 16'hBEEF;
        tick();
        clear16();
        checks++; if (d16.MDR !== 16'h0002 || d16.Mdr_Busy !== 1'b0) begin
            errors++; $display("FAIL mdr_abort got mdr=%h busy=%b want 0002 0", d16.MDR, d16.Mdr_Busy);
        end
    endtask

    task automatic test_simultaneous();
        d16.GatePC = 1; d16.LD_MAR = 1; d16.LD_IR = 1; d16.LD_MDR = 1; d16.MIO_EN = 0;
        d16.LD_REG = 1; d16.DRMUX = 1; d16.LD_CC = 1;
        tick();
        clear16();
        checks++; if (d16.MAR !== 16'h0002 || d16.IR !== 16'h0002 || d16.MDR !== 16'h0002 || d16.NZP !== 3'b001) begin
            errors++; $display("FAIL multi_load got mar=%h ir=%h mdr=%h nzp=%b want 0002 0002 0002 001", d16.MAR, d16.IR, d16.MDR, d16.NZP);
        end
        set_ir16(16'h01C0);
        reg_to_mar16(1'b1);
        checks++; if (d16.MAR !== 16'h0002) begin errors++; $display("FAIL multi_load_r7 got %h want 0002", d16.MAR); end
    endtask

    task automatic test_width32();
        clear32();
        d32.LD_MDR = 1; d32.MIO_EN = 1; d32.Mem_Rdy = 1; d32.MDR_In = 32'h0000_01FF;
        tick();
        clear32();
        d32.GateMDR = 1; d32.LD_IR = 1;
        tick();
        clear32();
        d32.GateMARMUX = 1; d32.LD_MAR = 1; d32.ADDR1MUX = 0; d32.ADDR2MUX = 2'b10;
        tick();
        checks++; if (d32.MAR !== 32'h0000_0FFF) begin errors++; $display("FAIL w32_off9 got %h want 00000fff", d32.MAR); end
        d32.ADDR2MUX = 2'b11;
        tick();
        clear32();
        checks++; if (d32.MAR !== 32'h0000_11FF) begin errors++; $display("FAIL w32_off11 got %h want 000011ff", d32.MAR); end
    endtask

    initial begin
        clear16();
        clear32();
        do_reset();
        test_reset();
        test_pc();
        test_alu_cc_ben();
        test_led();
        test_bus_err();
        test_mem_wait();
        test_simultaneous();
        test_width32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
